row_pixel_packer: RTL
=====================

# row_pixel_packer

Upstream feeder for `binary_threshold_filter`. Accepts a raster stream of 24-bit RGB pixels, one per cycle, over a valid/ready handshake. Assembles each group of `COL` pixels into one full-row bus in the filter's `row_in` layout. Presents completed rows on a row-level valid/ready handshake. A one-row fill buffer plus one output register lets the next row fill while the filter holds the current one.

## Interface
- `COL`, 256, pixels per row
- `WIDTH`, 8, bits per colour channel; pixel = 3*`WIDTH` bits
- `ROWS`, 256, rows per frame; used only with `PACKER_FRAME_CNT_EN`

Ports:
- `CLK`  in  1  single clock; all state changes on rising edge
- `RST`  in  1  synchronous, active-high reset
- `pix_in`  in  3*`WIDTH`  pixel; R in `[3W-1:2W]`, G in `[2W-1:W]`, B in `[W-1:0]`
- `pix_valid`  in  1  `pix_in` is valid
- `pix_ready`  out  1  packer accepts the pixel this cycle
- `row_out`  out  `COL`*3*`WIDTH`  packed row; pixel 0 in the MSBs, pixel j at `[(COL-j)*3W-1 -: 3W]`
- `row_valid`  out  1  `row_out` holds a complete row
- `row_ready`  in  1  consumer takes the row this cycle
- `row_idx`  out  clog2(`ROWS`)  row number of `row_out` (macro only)
- `frame_last`  out  1  current row is the last of the frame (macro only)

## Operation
- **State:** fill buffer `F` (`COL`*3W bits), column counter `col_cnt` (0..`COL`-1), flag `f_full`, output register `O` driving `row_out`, and `row_valid`.
- **Ready:** `pix_ready = !f_full`, combinational from `f_full` only; no dependence on `pix_valid`.
- **Pixel accept:** occurs on `pix_valid && pix_ready`.
  - Write `pix_in` to the `F` slot for `col_cnt`.
  - If `col_cnt == COL-1`: set `col_cnt` to 0 and set `f_full`. Otherwise increment `col_cnt`.
- **Transfer:** occurs when `f_full && (!row_valid || row_ready)`.
  - Load `O` from `F`, set `row_valid` to 1, clear `f_full`.
  - A transfer coincident with a row handshake replaces the row with no `row_valid` gap.
- **Drain:** when `row_valid && row_ready` and no transfer, clear `row_valid`. `O` keeps its stale contents.
- **Stability:** `row_out` is stable whenever `row_valid` is high and `row_ready` is low.
- **Unwritten slots:** `F` is not cleared between rows. Every slot is overwritten before `f_full` sets, so a partial row never reaches `O`.
- **Reset:** synchronous, and applies mid-row as well. Clears `col_cnt`, `f_full`, `row_valid`, `O` and `F` to 0. Any partial or pending row is discarded.
- **States:** implicit in (`f_full`, `row_valid`):
  - EMPTY (0,0)
  - OUT (0,1)
  - FULL (1,0): transient, lasts one cycle
  - BOTH (1,1): pixel input stalls until `row_ready`

## Timing
- **Reset values:** `pix_ready`=1, `row_valid`=0, `row_out`=0, `row_idx`=0, `frame_last`=0.
- **Latency:** last pixel of a row accepted at edge k. `f_full`=1 after edge k. `row_valid`=1 and `row_out` updated after edge k+1.
- **Bubble:** `pix_ready` is low for exactly one cycle per row (between edges k and k+1) when the output side is free. Sustained throughput is one row per `COL`+1 cycles.
- **Backpressure:** if `row_valid` is high and `row_ready` is low, `pix_ready` stays low until the cycle after the first `row_ready`=1 cycle.
- **Input holds:** `pix_valid` may drop at any time without losing state. `col_cnt` holds.

## Configuration
- **Macro:** `PACKER_FRAME_CNT_EN`.
- **When defined:**
  - Adds `row_idx` and `frame_last`.
  - `row_idx` increments, wrapping `ROWS`-1 to 0, on every row handshake (`row_valid && row_ready`).
  - `frame_last = row_valid && (row_idx == ROWS-1)`.
  - Reset sets `row_idx` to 0.
- **When undefined:** both ports and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `RST` 2 cycles -> `pix_ready`=1, `row_valid`=0, `row_out`=0.
- **Ordering:** stream 256 pixels `{j[7:0], 8'hA5, ~j[7:0]}` with `pix_valid` constant and `row_ready`=1.
  - -> `row_valid` rises 2 cycles after the last accept.
  - -> `row_out[6143:6120]`=24'h00A5FF and `row_out[23:0]`=24'hFFA500.
- **Backpressure:** hold `row_ready`=0 while a second row is streamed.
  - -> `pix_ready` drops after the 256th pixel of row 2.
  - -> `row_out` is unchanged.
  - -> one cycle of `row_ready` swaps in row 2 with no `row_valid` gap.
- **Input gaps:** toggle `pix_valid` randomly at 50%.
  - -> the packed row equals the gap-free result.
  - -> `col_cnt` never advances on `pix_valid`=0.
- **Reset mid-row:** reset after 100 pixels, then stream a full row.
  - -> the first emitted row contains only post-reset pixels.
  - -> no row is emitted before that.
- **Frame count (macro):** with `ROWS`=4, stream 5 rows.
  - -> `row_idx` reads 0,1,2,3,0.
  - -> `frame_last`=1 only while row 3 is presented.

Source files
------------

// File: rtl/row_pixel_packer_if.sv
// Pixel-stream in / row-stream out handshake bundle for row_pixel_packer.
// Carries row_idx and frame_last only when PACKER_FRAME_CNT_EN is defined.
interface row_pixel_packer_if #(
  parameter int unsigned COL   = 256,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 256
);
  logic [3*WIDTH-1:0]     pix_in;
  logic                   pix_valid;
  logic                   pix_ready;
  logic [COL*3*WIDTH-1:0] row_out;
  logic                   row_valid;
  logic                   row_ready;
`ifdef PACKER_FRAME_CNT_EN
  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx;
  logic                                       frame_last;
`endif

  modport master (
    output pix_in,
    output pix_valid,
    output row_ready,
    input  pix_ready,
    input  row_out,
    input  row_valid
`ifdef PACKER_FRAME_CNT_EN
    ,
    input  row_idx,
    input  frame_last
`endif
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    input  row_ready,
    output pix_ready,
    output row_out,
    output row_valid
`ifdef PACKER_FRAME_CNT_EN
    ,
    output row_idx,
    output frame_last
`endif
  );
endinterface

// File: rtl/row_pixel_packer.sv
// Packs a raster RGB pixel stream into full rows for binary_threshold_filter.
// Define PACKER_FRAME_CNT_EN to add the row_idx / frame_last frame counter.
module row_pixel_packer #(
  parameter int unsigned COL   = 256,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 256
) (
  input logic               CLK,
  input logic               RST,
  row_pixel_packer_if.slave bus
);
  localparam int unsigned PW = 3 * WIDTH;
  localparam int unsigned RW = COL * PW;
  localparam int unsigned CW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [CW-1:0] ColLast = CW'(COL - 1);

  logic [PW-1:0] f_q [COL];
  logic [RW-1:0] f_row;
  logic [RW-1:0] o_q;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic          f_full_q, f_full_d;
  logic          row_valid_q, row_valid_d;
  logic          accept;
  logic          xfer;

  assign bus.pix_ready = !f_full_q;
  assign bus.row_out   = o_q;
  assign bus.row_valid = row_valid_q;

  assign accept = bus.pix_valid && !f_full_q;
  // accept and xfer are mutually exclusive: one needs f_full low, the other high
  assign xfer   = f_full_q && (!row_valid_q || bus.row_ready);

  // Pixel 0 sits in the MSBs of the row bus
  always_comb begin
    f_row = '0;
    for (int j = 0; j < COL; j++) begin
      f_row[(COL - j) * PW - 1 -: PW] = f_q[j];
    end
  end

  always_comb begin
    col_cnt_d   = col_cnt_q;
    f_full_d    = f_full_q;
    row_valid_d = row_valid_q;
    if (accept) begin
      if (col_cnt_q == ColLast) begin
        col_cnt_d = '0;
        f_full_d  = 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
    if (xfer) begin
      f_full_d    = 1'b0;
      row_valid_d = 1'b1;
    end else if (row_valid_q && bus.row_ready) begin
      row_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int j = 0; j < COL; j++) begin
        f_q[j] <= '0;
      end
    end else if (accept) begin
      f_q[col_cnt_q] <= bus.pix_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      col_cnt_q   <= '0;
      f_full_q    <= 1'b0;
      row_valid_q <= 1'b0;
      o_q         <= '0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      f_full_q    <= f_full_d;
      row_valid_q <= row_valid_d;
      if (xfer) begin
        o_q <= f_row;
      end
    end
  end

`ifdef PACKER_FRAME_CNT_EN
  localparam int unsigned IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IW-1:0] RowLast = IW'(ROWS - 1);

  logic [IW-1:0] row_idx_q, row_idx_d;

  always_comb begin
    row_idx_d = row_idx_q;
    if (row_valid_q && bus.row_ready) begin
      row_idx_d = (row_idx_q == RowLast) ? '0 : row_idx_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_idx_q <= '0;
    end else begin
      row_idx_q <= row_idx_d;
    end
  end

  assign bus.row_idx    = row_idx_q;
  assign bus.frame_last = row_valid_q && (row_idx_q == RowLast);
`endif
endmodule
